// File: rtl/riscv_imem_loader.sv
// Boot-time instruction memory loader.
// Receives a framed byte stream (LEN_LO, LEN_HI, 4*N data bytes, CSUM), packs
// the data bytes little-endian into words, writes them to the instruction
// memory and releases the core from reset once the frame XOR checks to zero.
module riscv_imem_loader #(
    parameter int XLEN          = 32,
    parameter int IMEM_ADDR_BIT = 12
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_start,
    input  logic [7:0]               i_byte_data,
    input  logic                     i_byte_valid,
    output logic                     o_byte_ready,
    output logic                     o_imem_we,
    output logic [IMEM_ADDR_BIT-3:0] o_imem_addr,
    output logic [XLEN-1:0]          o_imem_wdata,
    output logic                     o_core_rstn,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err
);

    localparam int AW  = IMEM_ADDR_BIT - 2;            // word address width
    localparam int BPW = XLEN / 8;                     // bytes per word
    localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;  // byte counter width
    localparam logic [16:0] DEPTH    = 17'(2 ** AW);
    localparam logic [BW-1:0] LAST_B = BW'(BPW - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     len_q, len_d;            // word count N from the header
    logic [15:0]     word_cnt_q, word_cnt_d;  // index of the word being assembled
    logic [BW-1:0]   byte_cnt_q, byte_cnt_d;  // byte lane within the current word
    logic [7:0]      xor_q, xor_d;            // running XOR of every accepted byte
    logic [XLEN-1:0] pack_q, pack_d;          // partially assembled word
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            core_rstn_q, core_rstn_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic            ready;
    logic            fire;
    logic [15:0]     n_words;

    assign n_words = {i_byte_data, len_q[7:0]};
    assign fire    = i_byte_valid & ready;

    // Next-state logic and register updates for the whole load sequence
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_cnt_d  = word_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        xor_d       = xor_q;
        pack_d      = pack_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        core_rstn_d = core_rstn_q;
        done_d      = done_q;
        err_d       = err_q;
        ready       = 1'b0;

        if (state_q == S_LEN0 || state_q == S_LEN1 ||
            state_q == S_DATA || state_q == S_CSUM) begin
            ready = 1'b1;
        end

        if (fire) begin
            xor_d = xor_q ^ i_byte_data;
        end

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (i_start) begin
                    state_d     = S_LEN0;
                    word_cnt_d  = '0;
                    byte_cnt_d  = '0;
                    xor_d       = '0;
                    core_rstn_d = 1'b0;
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                end
            end
            S_LEN0: begin
                if (fire) begin
                    len_d[7:0] = i_byte_data;
                    state_d    = S_LEN1;
                end
            end
            S_LEN1: begin
                if (fire) begin
                    len_d = n_words;
                    if (n_words == 16'd0) begin
                        state_d = S_CSUM;
                    end else if ({1'b0, n_words} > DEPTH) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (fire) begin
                    for (int k = 0; k < BPW; k++) begin
                        if (byte_cnt_q == BW'(k)) begin
                            pack_d[8*k +: 8] = i_byte_data;
                        end
                    end
                    byte_cnt_d = byte_cnt_q + BW'(1);
                    if (byte_cnt_q == LAST_B) begin
                        // Word complete: present it on the write port next cycle
                        byte_cnt_d = '0;
                        we_d       = 1'b1;
                        wdata_d    = pack_d;
                        addr_d     = word_cnt_q[AW-1:0];
                        word_cnt_d = word_cnt_q + 16'd1;
                        if (word_cnt_q == len_q - 16'd1) begin
                            state_d = S_CSUM;
                        end
                    end
                end
            end
            S_CSUM: begin
                if (fire) begin
                    if ((xor_q ^ i_byte_data) == 8'h00) begin
                        state_d     = S_DONE;
                        done_d      = 1'b1;
                        core_rstn_d = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared by the asynchronous reset
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            word_cnt_q  <= '0;
            byte_cnt_q  <= '0;
            xor_q       <= '0;
            pack_q      <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            core_rstn_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            word_cnt_q  <= word_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            xor_q       <= xor_d;
            pack_q      <= pack_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            core_rstn_q <= core_rstn_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign o_byte_ready = ready;
    assign o_busy       = ready;
    assign o_imem_we    = we_q;
    assign o_imem_addr  = addr_q;
    assign o_imem_wdata = wdata_q;
    assign o_core_rstn  = core_rstn_q;
    assign o_done       = done_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_riscv_imem_loader.sv
// Directed bench for riscv_imem_loader: frames are driven byte by byte and
// every imem write is captured by a monitor for comparison.
module tb_riscv_imem_loader;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [7:0]  bdata;
    logic        bvalid;
    logic        bready;
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic        core_rstn;
    logic        busy;
    logic        done;
    logic        err;

    int n_pass  = 0;
    int n_total = 0;

    logic [9:0]  wr_addr [0:2047];
    logic [31:0] wr_data [0:2047];
    int          wr_cnt = 0;

    riscv_imem_loader #(.XLEN(32), .IMEM_ADDR_BIT(12)) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_start      (start),
        .i_byte_data  (bdata),
        .i_byte_valid (bvalid),
        .o_byte_ready (bready),
        .o_imem_we    (we),
        .o_imem_addr  (addr),
        .o_imem_wdata (wdata),
        .o_core_rstn  (core_rstn),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every write strobe, sampled mid-cycle
    always @(negedge clk) begin
        if (we) begin
            if (wr_cnt < 2048) begin
                wr_addr[wr_cnt] = addr;
                wr_data[wr_cnt] = wdata;
            end
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Called at a negedge; returns at the negedge after the byte was taken
    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int k;
        if (rnd) begin
            for (int g = 0; g < 3; g++) begin
                if ($urandom_range(0, 1) == 0) break;
                bvalid = 1'b0;
                @(negedge clk);
            end
        end
        bdata  = b;
        bvalid = 1'b1;
        k = 0;
        while (!bready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!bready) check("ready_timeout", 32'(bready), 32'd1);
        @(negedge clk);
        bvalid = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] q[$], input bit rnd);
        foreach (q[i]) send_byte(q[i], rnd);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Two-word frame; XOR of 02 00 13 00 00 00 93 00 10 00 is 92,
    // so a checksum byte of 92 closes the frame to zero.
    task automatic run_good(input string tag, input bit rnd);
        wr_cnt = 0;
        pulse_start();
        check({tag, "_busy"}, 32'(busy), 32'd1);
        send_bytes('{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                     8'h93, 8'h00, 8'h10, 8'h00}, rnd);
        check({tag, "_crst_pre"}, 32'(core_rstn), 32'd0);
        send_byte(8'h92, rnd);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_crst"}, 32'(core_rstn), 32'd1);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_ready"}, 32'(bready), 32'd0);
        check({tag, "_nwr"}, 32'(wr_cnt), 32'd2);
        check({tag, "_a0"}, 32'(wr_addr[0]), 32'd0);
        check({tag, "_d0"}, wr_data[0], 32'h00000013);
        check({tag, "_a1"}, 32'(wr_addr[1]), 32'd1);
        check({tag, "_d1"}, wr_data[1], 32'h00100093);
    endtask

    logic [7:0] full_q[$];
    logic [7:0] cs;
    logic [31:0] w;

    initial begin
        rstn   = 1'b0;
        start  = 1'b0;
        bdata  = 8'h00;
        bvalid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_crst", 32'(core_rstn), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_wdata", wdata, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Good two-word frame, back-to-back bytes
        run_good("s1", 1'b0);

        // Same frame with a bad checksum
        wr_cnt = 0;
        pulse_start();
        check("s2_done_clr", 32'(done), 32'd0);
        send_bytes('{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                     8'h93, 8'h00, 8'h10, 8'h00, 8'h93}, 1'b0);
        check("s2_err", 32'(err), 32'd1);
        check("s2_done", 32'(done), 32'd0);
        check("s2_crst", 32'(core_rstn), 32'd0);
        check("s2_nwr", 32'(wr_cnt), 32'd2);
        check("s2_d1", wr_data[1], 32'h00100093);

        // Empty image
        wr_cnt = 0;
        pulse_start();
        check("s3_err_clr", 32'(err), 32'd0);
        send_bytes('{8'h00, 8'h00, 8'h00}, 1'b0);
        check("s3_done", 32'(done), 32'd1);
        check("s3_crst", 32'(core_rstn), 32'd1);
        check("s3_nwr", 32'(wr_cnt), 32'd0);

        // Length 1025 exceeds the 1024-word memory
        wr_cnt = 0;
        pulse_start();
        send_bytes('{8'h01, 8'h04}, 1'b0);
        check("s4_err", 32'(err), 32'd1);
        check("s4_ready", 32'(bready), 32'd0);
        check("s4_busy", 32'(busy), 32'd0);
        check("s4_crst", 32'(core_rstn), 32'd0);
        repeat (2) @(negedge clk);
        check("s4_nwr", 32'(wr_cnt), 32'd0);

        // Good frame with a stalling stream
        run_good("s5", 1'b1);

        // Reset after three data bytes, then a clean load
        wr_cnt = 0;
        pulse_start();
        send_bytes('{8'h02, 8'h00, 8'h13, 8'h00, 8'h00}, 1'b0);
        rstn = 1'b0;
        #1;
        check("s6_rst_busy", 32'(busy), 32'd0);
        check("s6_rst_crst", 32'(core_rstn), 32'd0);
        check("s6_rst_addr", 32'(addr), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        check("s6_nwr_partial", 32'(wr_cnt), 32'd0);
        run_good("s6", 1'b0);

        // i_start in the middle of DATA must not restart the frame
        wr_cnt = 0;
        pulse_start();
        send_bytes('{8'h02, 8'h00, 8'h13, 8'h00}, 1'b0);
        pulse_start();
        check("s7_busy", 32'(busy), 32'd1);
        send_bytes('{8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h92}, 1'b0);
        check("s7_done", 32'(done), 32'd1);
        check("s7_nwr", 32'(wr_cnt), 32'd2);
        check("s7_d0", wr_data[0], 32'h00000013);

        // Full-depth image: 1024 words, word i = {i, ~i}
        full_q = '{8'h00, 8'h04};
        cs = 8'h04;
        for (int i = 0; i < 1024; i++) begin
            w = {16'(i), ~16'(i)};
            for (int b = 0; b < 4; b++) begin
                full_q.push_back(w[8*b +: 8]);
                cs = cs ^ w[8*b +: 8];
            end
        end
        full_q.push_back(cs);
        wr_cnt = 0;
        pulse_start();
        send_bytes(full_q, 1'b0);
        check("s8_done", 32'(done), 32'd1);
        check("s8_nwr", 32'(wr_cnt), 32'd1024);
        check("s8_a_last", 32'(wr_addr[1023]), 32'd1023);
        check("s8_d_last", wr_data[1023], {16'd1023, ~16'd1023});
        check("s8_d_mid", wr_data[517], {16'd517, ~16'd517});
        repeat (3) @(negedge clk);
        check("s8_nwr_after", 32'(wr_cnt), 32'd1024);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
